// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings from decode, FSM states and default cycle counts.
package mdu_pkg;

  localparam int MDU_WIDTH_DEF       = 32;
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: signed/unsigned 2W-bit product and quotient/remainder.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DEF
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic               signed_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    // Low 2W bits of the sign-extended product equal the signed product.
    a_sx   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    b_sx   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    a_zx   = {{WIDTH{1'b0}}, a_i};
    b_zx   = {{WIDTH{1'b0}}, b_i};
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;

    signed_div = (op_i == MDU_DIV);
    a_neg      = signed_div & a_i[WIDTH-1];
    b_neg      = signed_div & b_i[WIDTH-1];
    a_mag      = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag      = b_neg ? (~b_i + 1'b1) : b_i;
    // Magnitude divide keeps most-negative / -1 well defined (wraps to itself).
    b_safe     = (b_i == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem        = a_neg ? (~r_mag + 1'b1) : r_mag;
    div_zero_o = (b_i == '0);

    hi_o = '0;
    lo_o = '0;
    case (op_i)
      MDU_MULT:  {hi_o, lo_o} = prod_s;
      MDU_MULTU: {hi_o, lo_o} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        hi_o = rem;
        lo_o = quot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: busy countdown, pending result, HI/LO ownership and D-stage stall.
// Optional MDU_CANCEL_EN adds a cancel port that aborts in-flight or E-stage ops.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH_DEF,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic [3:0]       e_mdu_op,
  input  logic             e_start,
  input  logic [WIDTH-1:0] e_a,
  input  logic [WIDTH-1:0] e_b,
  input  logic             d_mdu_use,
  output logic [WIDTH-1:0] e_rd_data,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q, cnt_load_d;
  logic             busy_q, pend_dz_q;
  logic [WIDTH-1:0] hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic [WIDTH-1:0] calc_hi, calc_lo;
  logic             calc_dz, cancel_w, launch_op;

`ifdef MDU_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op_i       (e_mdu_op),
    .a_i        (e_a),
    .b_i        (e_b),
    .hi_o       (calc_hi),
    .lo_o       (calc_lo),
    .div_zero_o (calc_dz)
  );

  assign launch_op  = e_start & is_multicycle(e_mdu_op);
  assign cnt_load_d = is_div(e_mdu_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (e_start && !cancel_w) begin
            if (launch_op) begin
              state_q   <= ST_BUSY;
              busy_q    <= 1'b1;
              cnt_q     <= cnt_load_d;
              pend_hi_q <= calc_hi;
              pend_lo_q <= calc_lo;
              pend_dz_q <= is_div(e_mdu_op) & calc_dz;
            end else if (e_mdu_op == MDU_MTHI) begin
              hi_q <= e_a;
            end else if (e_mdu_op == MDU_MTLO) begin
              lo_q <= e_a;
            end
          end
        end
        ST_BUSY: begin
          // Any E-stage op arriving here is ignored; stall keeps the pipeline honest.
          if (cancel_w) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (!pend_dz_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    e_rd_data = '0;
    if (e_mdu_op == MDU_MFHI)      e_rd_data = hi_q;
    else if (e_mdu_op == MDU_MFLO) e_rd_data = lo_q;
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = d_mdu_use & (busy_q | launch_op);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic results, stall window, mthi/mtlo, reset abort.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cancel;
  logic [3:0]  e_mdu_op;
  logic        e_start;
  logic [31:0] e_a, e_b;
  logic        d_mdu_use;
  logic [31:0] e_rd_data, hi, lo;
  logic        busy, stall;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MDU_CANCEL_EN
    .cancel    (cancel),
`endif
    .e_mdu_op  (e_mdu_op),
    .e_start   (e_start),
    .e_a       (e_a),
    .e_b       (e_b),
    .d_mdu_use (d_mdu_use),
    .e_rd_data (e_rd_data),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .stall     (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one multi-cycle op, check busy for n cycles and old HI held, then the new HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    int busy_cnt;
    busy_cnt   = 0;
    e_mdu_op   = op;
    e_start    = 1'b1;
    e_a        = a;
    e_b        = b;
    #1;
    chk({tag, " no-stall"}, {31'd0, stall}, 32'd0);
    step();
    e_start  = 1'b0;
    e_mdu_op = 4'd0;
    for (int i = 0; i < n; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (i == n - 1) chk({tag, " hi-held"}, hi, exp_hi);
      step();
    end
    chk({tag, " busy-cycles"}, busy_cnt, n);
    chk({tag, " busy-fall"}, {31'd0, busy}, 32'd0);
    chk({tag, " hi"}, hi, new_hi);
    chk({tag, " lo"}, lo, new_lo);
    $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, a, b, hi, lo);
    exp_hi = new_hi;
    exp_lo = new_lo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cancel = 1'b0; e_mdu_op = 4'd0; e_start = 1'b0;
    e_a = '0; e_b = '0; d_mdu_use = 1'b0;
    exp_hi = '0; exp_lo = '0;
    step(); step();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    step();

    run_op("mult",  4'd1, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div",   4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0", 4'd4, 32'd55, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div-b", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",  4'd4, 32'd100, 32'd7, 10, 32'h00000002, 32'h0000000E);
    run_op("multn", 4'd1, 32'hFFFFFFFD, 32'hFFFFFFFB, 5, 32'h00000000, 32'h0000000F);

    // mult followed by a dependent mflo in D: stall from launch until busy falls.
    e_mdu_op = 4'd1; e_start = 1'b1; e_a = 32'd3; e_b = 32'd4; d_mdu_use = 1'b1;
    #1;
    chk("stall launch", {31'd0, stall}, 32'd1);
    step();
    e_start = 1'b0; e_mdu_op = 4'd0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall busy%0d", i), {31'd0, stall}, 32'd1);
      step();
    end
    chk("stall drop", {31'd0, stall}, 32'd0);
    chk("stall busy-fall", {31'd0, busy}, 32'd0);
    e_mdu_op = 4'd6; e_start = 1'b1;
    #1;
    chk("mflo data", e_rd_data, 32'h0000000C);
    e_mdu_op = 4'd5;
    #1;
    chk("mfhi data", e_rd_data, 32'h00000000);
    step();
    chk("mfhi no-busy", {31'd0, busy}, 32'd0);
    chk("mfhi lo-kept", lo, 32'h0000000C);
    e_start = 1'b0; e_mdu_op = 4'd0; d_mdu_use = 1'b0;
    #1;
    chk("rd idle", e_rd_data, 32'd0);
    $display("txn stall/mflo lo=%h", lo);

    // mthi / mtlo in IDLE
    e_mdu_op = 4'd7; e_start = 1'b1; e_a = 32'h12345678;
    step();
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    e_mdu_op = 4'd8; e_a = 32'hCAFEF00D;
    step();
    chk("mtlo lo", lo, 32'hCAFEF00D);
    chk("mtlo hi-kept", hi, 32'h12345678);
    e_mdu_op = 4'd5;
    #1;
    chk("mfhi after mthi", e_rd_data, 32'h12345678);
    $display("txn mthi/mtlo hi=%h lo=%h", hi, lo);

    // E-stage ops during BUSY, including across the completion edge, are ignored.
    e_mdu_op = 4'd1; e_start = 1'b1; e_a = 32'd2; e_b = 32'd3;
    step();
    e_mdu_op = 4'd7; e_a = 32'hDEADBEEF;
    chk("ign busy1", {31'd0, busy}, 32'd1);
    step();
    e_mdu_op = 4'd1; e_a = 32'd100; e_b = 32'd100;
    chk("ign hi-held", hi, 32'h12345678);
    step(); step(); step();
    chk("ign busy5", {31'd0, busy}, 32'd1);
    step();
    e_start = 1'b0; e_mdu_op = 4'd0;
    chk("ign busy-fall", {31'd0, busy}, 32'd0);
    chk("ign hi", hi, 32'h00000000);
    chk("ign lo", lo, 32'h00000006);
    step();
    chk("ign no-relaunch", {31'd0, busy}, 32'd0);
    $display("txn ignore-in-busy hi=%h lo=%h", hi, lo);

    // Asynchronous reset in cycle 3 of a divide
    e_mdu_op = 4'd3; e_start = 1'b1; e_a = 32'd100; e_b = 32'd7;
    step();
    e_start = 1'b0; e_mdu_op = 4'd0;
    step(); step();
    chk("rst-mid busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst-mid busy0", {31'd0, busy}, 32'd0);
    chk("rst-mid hi", hi, 32'd0);
    chk("rst-mid lo", lo, 32'd0);
    #3 rst_n = 1'b1;
    step(); step();
    chk("rst-mid stays idle", {31'd0, busy}, 32'd0);
    chk("rst-mid lo kept", lo, 32'd0);
    $display("txn reset-mid-div hi=%h lo=%h", hi, lo);

`ifdef MDU_CANCEL_EN
    e_mdu_op = 4'd7; e_start = 1'b1; e_a = 32'h11;
    step();
    e_mdu_op = 4'd8; e_a = 32'h22;
    step();
    e_mdu_op = 4'd3; e_a = 32'd100; e_b = 32'd7;
    step();
    e_start = 1'b0; e_mdu_op = 4'd0;
    step(); step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel busy0", {31'd0, busy}, 32'd0);
    chk("cancel hi", hi, 32'h11);
    chk("cancel lo", lo, 32'h22);
    step();
    chk("cancel lo later", lo, 32'h22);
    e_mdu_op = 4'd7; e_start = 1'b1; e_a = 32'h99; cancel = 1'b1;
    step();
    chk("cancel mthi", hi, 32'h11);
    e_mdu_op = 4'd1;
    step();
    chk("cancel launch", {31'd0, busy}, 32'd0);
    cancel = 1'b0; e_start = 1'b0; e_mdu_op = 4'd0;
    $display("txn cancel hi=%h lo=%h", hi, lo);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
